// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared unit encodings, write-back selects and widths
package riscv_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BRANCH = 3'd1,
    UNIT_MUL    = 3'd2,
    UNIT_DIV    = 3'd3,
    UNIT_LOAD   = 3'd4,
    UNIT_STORE  = 3'd5
  } unit_e;

  localparam logic [1:0] WB_EX  = 2'b00;
  localparam logic [1:0] WB_MUL = 2'b01;
  localparam logic [1:0] WB_DIV = 2'b10;
endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - ID-side decode inputs and issue/write-back decisions
interface issue_ctrl_if;
  import riscv_pkg::*;

  logic             id_valid;
  logic [2:0]       id_unit;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_dest;
  logic             is_branched;
  logic             stall;
  logic             issue;
  logic             mul_start;
  logic             div_start;
  logic [1:0]       wb_sel;
  logic [REG_W-1:0] wb_dest;
  logic [31:0]      pending;

  modport master (
    output id_valid, id_unit, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_dest, is_branched,
    input  stall, issue, mul_start, div_start, wb_sel, wb_dest, pending
  );

  modport slave (
    input  id_valid, id_unit, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_dest, is_branched,
    output stall, issue, mul_start, div_start, wb_sel, wb_dest, pending
  );
endinterface

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - latency down-counter with the dest of the in-flight op
module lat_counter
  import riscv_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [REG_W-1:0] load_dest,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic [REG_W-1:0] dest
);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      dest <= '0;
    end else if (load) begin
      cnt  <= CNT_W'(LAT);
      dest <= load_dest;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - ID-stage issue/stall/flush decision, scoreboard and WB port arbiter
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        reset,
  issue_ctrl_if.slave bus
);
  logic [31:0]      pending_q;
  logic [31:0]      pending_next;
  logic [REG_W-1:0] ex_dest;
  logic [REG_W-1:0] wb_q_dest;
  logic [CNT_W-1:0] mul_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic             mul_done;
  logic             div_done;
  logic [REG_W-1:0] mul_dest;
  logic [REG_W-1:0] div_dest;
  logic             is_mul;
  logic             is_div;
  logic             is_writer;
  logic             raw_haz;
  logic             waw_haz;
  logic             struct_haz;
  logic             port_haz;
  logic             stall;
  logic             issue;
  logic             mul_start;
  logic             div_start;
  logic [1:0]       wb_sel;
  logic [REG_W-1:0] wb_dest;

  assign is_mul    = (bus.id_unit == UNIT_MUL);
  assign is_div    = (bus.id_unit == UNIT_DIV);
  assign is_writer = (bus.id_dest != '0);

  assign raw_haz = (bus.id_use_rs1 && bus.id_rs1 != '0 && pending_q[bus.id_rs1]) ||
                   (bus.id_use_rs2 && bus.id_rs2 != '0 && pending_q[bus.id_rs2]);
  assign waw_haz    = is_writer && pending_q[bus.id_dest];
  assign struct_haz = (is_mul && mul_cnt > CNT_W'(1)) || (is_div && div_cnt > CNT_W'(1));
  // An op issued now reaches the WB port in the same cycle as the listed in-flight unit
  assign port_haz = (is_writer && !is_mul && !is_div &&
                     (mul_cnt == CNT_W'(2) || div_cnt == CNT_W'(2))) ||
                    (is_mul && div_cnt == CNT_W'(MUL_LAT + 1));

  assign stall     = bus.id_valid && !bus.is_branched && !reset &&
                     (raw_haz || waw_haz || struct_haz || port_haz);
  assign issue     = bus.id_valid && !stall && !bus.is_branched && !reset;
  assign mul_start = issue && is_mul;
  assign div_start = issue && is_div;

  lat_counter #(.LAT(MUL_LAT)) u_mul_cnt (
    .clk(clk), .reset(reset), .load(mul_start), .load_dest(bus.id_dest),
    .cnt(mul_cnt), .done(mul_done), .dest(mul_dest)
  );

  lat_counter #(.LAT(DIV_LAT)) u_div_cnt (
    .clk(clk), .reset(reset), .load(div_start), .load_dest(bus.id_dest),
    .cnt(div_cnt), .done(div_done), .dest(div_dest)
  );

  always_comb begin
    wb_sel  = WB_EX;
    wb_dest = ex_dest;
    if (reset) begin
      wb_sel  = WB_EX;
      wb_dest = '0;
    end else if (div_done) begin
      wb_sel  = WB_DIV;
      wb_dest = div_dest;
    end else if (mul_done) begin
      wb_sel  = WB_MUL;
      wb_dest = mul_dest;
    end
  end

  // Clear follows the regfile write of the WB occupant; a same-edge set wins
  always_comb begin
    pending_next = pending_q;
    if (wb_q_dest != '0) pending_next[wb_q_dest] = 1'b0;
    if (issue && is_writer) pending_next[bus.id_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      ex_dest   <= '0;
      wb_q_dest <= '0;
    end else begin
      pending_q <= pending_next;
      ex_dest   <= (issue && !is_mul && !is_div) ? bus.id_dest : '0;
      wb_q_dest <= wb_dest;
    end
  end

  assign bus.stall     = stall;
  assign bus.issue     = issue;
  assign bus.mul_start = mul_start;
  assign bus.div_start = div_start;
  assign bus.wb_sel    = wb_sel;
  assign bus.wb_dest   = wb_dest;
  assign bus.pending   = reset ? 32'h0 : pending_q;
endmodule
